// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: base opcodes, immediate formats and
// per-opcode source-usage helpers used by the decode stage and imm_gen.
package rv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } imm_fmt_e;

    // Immediate format selected by the major opcode
    function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
        imm_fmt_e f;
        case (op)
            OP_LOAD, OP_IMM, OP_JALR: f = FMT_I;
            OP_STORE:                 f = FMT_S;
            OP_BRANCH:                f = FMT_B;
            OP_LUI, OP_AUIPC:         f = FMT_U;
            OP_JAL:                   f = FMT_J;
            default:                  f = FMT_NONE;
        endcase
        return f;
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_REG || op == OP_STORE || op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator for all RV32I base formats.
// Ports: inst (instruction word) -> imm (sign-extended to XLEN; 0 for
// opcodes without an immediate).
module imm_gen
    import rv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm
);

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_fmt(inst[6:0]))
            FMT_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U:   imm32 = {inst[31:12], 12'b0};
            FMT_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Signed source, so the size cast sign-extends to XLEN
    assign imm = XLEN'(imm32);

endmodule

// File: rtl/decode_regfile_stage.sv
// Registered RV32I decode stage with register file, write-back bypass,
// load-use scoreboard, held-bundle operand refresh and stall counter.
// Ports: clk/rst (async active-high); in_valid/in_ready/inst/in_pc from
// fetch; out_valid/out_ready and the decoded out_* bundle to execute;
// wb_en/wb_rd/wb_data/wb_is_load write-back; stall_cnt hazard-stall count.
module decode_regfile_stage
    import rv_pkg::*;
#(
    parameter int unsigned         XLEN      = XLEN_DEFAULT,
    parameter int unsigned         NREG      = 32,
    parameter int unsigned         RESET_REG = 31,
    parameter logic [XLEN-1:0]     RESET_VAL = XLEN'(32'hFFFFFC50),
    localparam int unsigned        RW        = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [RW-1:0]   out_rd,
    output logic [XLEN-1:0] out_rs1_data,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_imm,
    input  logic            wb_en,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            wb_is_load,
    output logic [31:0]     stall_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_clr;
    logic [NREG-1:0] busy_nxt;

    logic [6:0]      opcode;
    logic [RW-1:0]   rs1, rs2, rd;
    logic            use1, use2;
    logic [XLEN-1:0] rs1_val, rs2_val, imm;
    logic            hazard, accept;

    logic [RW-1:0]   hold_rs1, hold_rs2;
    logic            hold_use1, hold_use2;

    assign opcode = inst[6:0];
    assign rs1    = RW'(inst[19:15]);
    assign rs2    = RW'(inst[24:20]);
    assign rd     = RW'(inst[11:7]);
    assign use1   = uses_rs1(opcode);
    assign use2   = uses_rs2(opcode);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst (inst),
        .imm  (imm)
    );

    // Operand read: x0 is hardwired, same-cycle write-back wins over the file
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != '0) rs1_val = (wb_en && wb_rd == rs1) ? wb_data : regs[rs1];
        if (rs2 != '0) rs2_val = (wb_en && wb_rd == rs2) ? wb_data : regs[rs2];
    end

    // Retiring load releases its bit before the hazard check
    always_comb begin
        busy_clr = busy;
        if (wb_en && wb_is_load) busy_clr[wb_rd] = 1'b0;
    end

    assign hazard   = (use1 && busy_clr[rs1]) || (use2 && busy_clr[rs2]);
    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;

    // Set is applied after clear so a same-index set wins
    always_comb begin
        busy_nxt = busy_clr;
        if (accept && opcode == OP_LOAD && rd != '0) busy_nxt[rd] = 1'b1;
    end

    // Architectural register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= (i == RESET_REG) ? RESET_VAL : '0;
            end
        end else if (wb_en && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Scoreboard
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_nxt;
    end

    // Output bundle: load on accept, drop on consume, refresh while held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            out_opcode   <= '0;
            out_funct3   <= '0;
            out_funct7   <= '0;
            out_rd       <= '0;
            out_rs1_data <= '0;
            out_rs2_data <= '0;
            out_imm      <= '0;
            hold_rs1     <= '0;
            hold_rs2     <= '0;
            hold_use1    <= 1'b0;
            hold_use2    <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            out_opcode   <= opcode;
            out_funct3   <= inst[14:12];
            out_funct7   <= inst[31:25];
            out_rd       <= rd;
            out_rs1_data <= rs1_val;
            out_rs2_data <= rs2_val;
            out_imm      <= imm;
            hold_rs1     <= rs1;
            hold_rs2     <= rs2;
            hold_use1    <= use1;
            hold_use2    <= use2;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            if (wb_en && wb_rd != '0 && hold_use1 && wb_rd == hold_rs1) out_rs1_data <= wb_data;
            if (wb_en && wb_rd != '0 && hold_use2 && wb_rd == hold_rs2) out_rs2_data <= wb_data;
        end
    end

    // Saturating hazard-stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_valid && hazard && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_decode_regfile_stage.sv
// Bench for decode_regfile_stage: directed scenarios plus random traffic,
// all checked against a cycle-level behavioural model of the stage.
module tb_decode_regfile_stage;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic [4:0]  out_rd;
    logic [31:0] out_rs1_data;
    logic [31:0] out_rs2_data;
    logic [31:0] out_imm;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        wb_is_load = 1'b0;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    decode_regfile_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .inst         (inst),
        .in_pc        (in_pc),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_opcode   (out_opcode),
        .out_funct3   (out_funct3),
        .out_funct7   (out_funct7),
        .out_rd       (out_rd),
        .out_rs1_data (out_rs1_data),
        .out_rs2_data (out_rs2_data),
        .out_imm      (out_imm),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_is_load   (wb_is_load),
        .stall_cnt    (stall_cnt)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_regs [32];
    bit          m_busy [32];
    logic        m_valid, m_ready;
    logic [31:0] m_pc, m_imm, m_rs1d, m_rs2d, m_stall;
    logic [6:0]  m_op, m_f7;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd;
    int          m_hrs1, m_hrs2;
    bit          m_hu1, m_hu2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 32; k++) begin
            m_regs[k] = (k == 31) ? 32'hFFFFFC50 : 32'h0;
            m_busy[k] = 1'b0;
        end
        m_valid = 0; m_ready = 1; m_pc = 0; m_imm = 0; m_rs1d = 0; m_rs2d = 0;
        m_stall = 0; m_op = 0; m_f7 = 0; m_f3 = 0; m_rd = 0;
        m_hrs1 = 0; m_hrs2 = 0; m_hu1 = 0; m_hu2 = 0;
    endfunction

    // Immediate value computed arithmetically from the field weights
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int v;
        v = 0;
        case (i[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                v = int'(i[31:20]) - (i[31] ? 4096 : 0);
            OP_STORE:
                v = int'(i[31:25]) * 32 + int'(i[11:7]) - (i[31] ? 4096 : 0);
            OP_BRANCH:
                v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2 - (i[31] ? 4096 : 0);
            OP_LUI, OP_AUIPC:
                v = int'(i[31:12]) * 4096;
            OP_JAL:
                v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2
                    - (i[31] ? 1048576 : 0);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic bit ref_u1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic bit ref_u2(input logic [6:0] op);
        return op == OP_REG || op == OP_STORE || op == OP_BRANCH;
    endfunction

    function automatic logic [31:0] rdval(input int r, input logic we, input logic [4:0] wrd,
                                          input logic [31:0] wd);
        if (r == 0) return 32'h0;
        if (we && int'(wrd) == r) return wd;
        return m_regs[r];
    endfunction

    // One clock: drive inputs, check in_ready, advance model, check outputs
    task automatic step(input logic v, input logic [31:0] i, input logic [31:0] pc,
                        input logic ordy, input logic we, input logic [4:0] wrd,
                        input logic [31:0] wd, input logic wld);
        bit bz [32];
        bit haz, acc;
        int r1, r2, rdi;
        logic [31:0] v1, v2;
        @(negedge clk);
        in_valid = v; inst = i; in_pc = pc; out_ready = ordy;
        wb_en = we; wb_rd = wrd; wb_data = wd; wb_is_load = wld;
        r1 = int'(i[19:15]); r2 = int'(i[24:20]); rdi = int'(i[11:7]);
        bz = m_busy;
        if (we && wld) bz[wrd] = 1'b0;
        haz = (ref_u1(i[6:0]) && bz[r1]) || (ref_u2(i[6:0]) && bz[r2]);
        m_ready = (!m_valid || ordy) && !haz;
        acc = v && m_ready;
        v1 = rdval(r1, we, wrd, wd);
        v2 = rdval(r2, we, wrd, wd);
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        if (acc) begin
            m_valid = 1; m_pc = pc; m_op = i[6:0]; m_f3 = i[14:12]; m_f7 = i[31:25];
            m_rd = i[11:7]; m_rs1d = v1; m_rs2d = v2; m_imm = ref_imm(i);
            m_hrs1 = r1; m_hrs2 = r2; m_hu1 = ref_u1(i[6:0]); m_hu2 = ref_u2(i[6:0]);
        end else if (m_valid && ordy) begin
            m_valid = 0;
        end else if (m_valid) begin
            if (we && wrd != 0 && m_hu1 && int'(wrd) == m_hrs1) m_rs1d = wd;
            if (we && wrd != 0 && m_hu2 && int'(wrd) == m_hrs2) m_rs2d = wd;
        end
        if (acc && i[6:0] == OP_LOAD && rdi != 0) bz[rdi] = 1'b1;
        m_busy = bz;
        if (we && wrd != 0) m_regs[wrd] = wd;
        if (v && haz && m_stall != 32'hFFFFFFFF) m_stall = m_stall + 1;
        @(posedge clk);
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_pc", out_pc, m_pc);
        chk("out_opcode", 32'(out_opcode), 32'(m_op));
        chk("out_funct3", 32'(out_funct3), 32'(m_f3));
        chk("out_funct7", 32'(out_funct7), 32'(m_f7));
        chk("out_rd", 32'(out_rd), 32'(m_rd));
        chk("out_rs1_data", out_rs1_data, m_rs1d);
        chk("out_rs2_data", out_rs2_data, m_rs2d);
        chk("out_imm", out_imm, m_imm);
        chk("stall_cnt", stall_cnt, m_stall);
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, OP_REG};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, 3'b010, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BRANCH};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [11];
        logic [31:0] r;
        ops = '{OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_REG, OP_LUI, OP_AUIPC,
                OP_JAL, OP_JALR, 7'b0001111, 7'b1110011};
        r = $urandom;
        r[6:0]   = ops[$urandom % 11];
        r[11:7]  = 5'($urandom % 8);
        r[19:15] = 5'($urandom % 8);
        r[24:20] = 5'($urandom % 8);
        return r;
    endfunction

    function automatic int find_busy();
        int s;
        s = int'($urandom % 32);
        for (int k = 0; k < 32; k++) begin
            if (m_busy[(s + k) % 32]) return (s + k) % 32;
        end
        return 0;
    endfunction

    initial begin
        bit hold;
        logic rv, rord, rwe, rwl;
        logic [31:0] ri, rpc, rwd;
        logic [4:0] rwr;
        int b;

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_stall_cnt", stall_cnt, 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_out_imm", out_imm, 32'h0);
        rst = 1'b0;

        // Reset register values
        step(1, enc_r(5'd1, 5'd31, 5'd0), 32'h100, 1, 0, 0, 0, 0);
        chk("x31_reset", out_rs1_data, 32'hFFFFFC50);
        step(1, enc_r(5'd2, 5'd0, 5'd31), 32'h104, 1, 0, 0, 0, 0);
        chk("x0_read", out_rs1_data, 32'h0);

        // Immediates
        step(1, enc_b(13'h1FFC, 5'd2, 5'd1), 32'h108, 1, 0, 0, 0, 0);
        chk("imm_beq_m4", out_imm, 32'hFFFFFFFC);
        step(1, {20'h12345, 5'd5, OP_LUI}, 32'h10C, 1, 0, 0, 0, 0);
        chk("imm_lui", out_imm, 32'h12345000);
        step(1, enc_j(21'd2048, 5'd1), 32'h110, 1, 0, 0, 0, 0);
        chk("imm_jal_2048", out_imm, 32'h00000800);
        step(1, enc_s(12'hFFF, 5'd2, 5'd1), 32'h114, 1, 0, 0, 0, 0);
        chk("imm_sw_m1", out_imm, 32'hFFFFFFFF);

        // Same-cycle write-back bypass
        step(1, enc_r(5'd1, 5'd3, 5'd0), 32'h118, 1, 1, 5'd3, 32'hDEADBEEF, 0);
        chk("bypass_rs1", out_rs1_data, 32'hDEADBEEF);

        // Load-use stall then release by the retiring load
        step(1, enc_i(12'h0, 5'd0, 5'd7, OP_LOAD), 32'h11C, 1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(1, enc_r(5'd8, 5'd7, 5'd7), 32'h120, 1, 0, 0, 0, 0);
            chk("ldu_stalled", 32'(in_ready), 32'h0);
        end
        step(1, enc_r(5'd8, 5'd7, 5'd7), 32'h120, 1, 1, 5'd7, 32'd5, 1);
        chk("ldu_rs1", out_rs1_data, 32'd5);
        chk("ldu_rs2", out_rs2_data, 32'd5);
        chk("ldu_stall_cnt", stall_cnt, 32'd3);
        step(1, enc_r(5'd9, 5'd7, 5'd0), 32'h124, 1, 0, 0, 0, 0);
        chk("ldu_busy_clr", 32'(out_rd), 32'd9);

        // Backpressure with held-operand refresh
        step(1, enc_r(5'd10, 5'd3, 5'd4), 32'h128, 1, 0, 0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 1, 5'd4, 32'd9, 0);
        chk("bp_rs2_refresh", out_rs2_data, 32'd9);
        chk("bp_in_ready", 32'(in_ready), 32'h0);
        step(0, 32'h0, 32'h0, 1, 0, 0, 0, 0);
        chk("bp_consumed", 32'(out_valid), 32'h0);

        // x0 handling
        step(0, 32'h0, 32'h0, 1, 1, 5'd0, 32'h1, 0);
        step(1, enc_r(5'd1, 5'd0, 5'd0), 32'h12C, 1, 0, 0, 0, 0);
        chk("x0_write_ignored", out_rs1_data, 32'h0);
        step(1, enc_i(12'h0, 5'd1, 5'd0, OP_LOAD), 32'h130, 1, 0, 0, 0, 0);
        step(1, enc_r(5'd2, 5'd0, 5'd0), 32'h134, 1, 0, 0, 0, 0);
        chk("lw_x0_nostall", 32'(out_rd), 32'd2);

        // Reset in the middle of a held bundle with an outstanding load
        step(1, enc_i(12'h4, 5'd0, 5'd6, OP_LOAD), 32'h138, 1, 0, 0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1; in_valid = 0; wb_en = 1; wb_rd = 5'd5; wb_data = 32'h77;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_stall", stall_cnt, 32'h0);
        @(posedge clk);
        @(negedge clk);
        wb_en = 0; wb_rd = 0; wb_data = 0; out_ready = 0;
        rst = 1'b0;
        model_reset();
        step(1, enc_r(5'd1, 5'd5, 5'd6), 32'h200, 1, 0, 0, 0, 0);
        chk("post_rst_x5", out_rs1_data, 32'h0);

        // Random traffic
        hold = 0; rv = 0; ri = 0; rpc = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold) begin
                rv  = ($urandom % 4) != 0;
                ri  = rand_inst();
                rpc = $urandom;
            end
            rord = ($urandom % 4) != 0;
            rwe = 0; rwr = 0; rwl = 0; rwd = $urandom;
            if ($urandom % 3 == 0) begin
                b = find_busy();
                if (b != 0) begin rwe = 1; rwr = 5'(b); rwl = 1; end
            end else if ($urandom % 3 == 0) begin
                rwe = 1; rwr = 5'($urandom % 8); rwl = ($urandom % 8) == 0;
            end
            step(rv, ri, rpc, rord, rwe, rwr, rwd, rwl);
            hold = rv && !m_ready;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
